// File: rtl/detector_pkg.sv
// -----------------------------------------------------------------------------
// detector_pkg
// Shared constants, the arbiter state type and the time-tag word builder used by
// the detector stream arbiter and the link-side blocks.
//
// Tag word layout (MSB first):
//   [127:123] frame mark 5'b11111 (same framing as an event word)
//   [122]     single-event flag, always 0 for a tag
//   [121:116] block id 6'h3F (reserved id meaning "time tag")
//   [115:48]  zero padding
//   [47:0]    time-tag period
// -----------------------------------------------------------------------------
package detector_pkg;

  localparam int DATA_BITS    = 128;
  localparam int PERIOD_BITS  = 48;
  localparam int FRAME_BITS   = 5;
  localparam int BLOCK_ID_BITS = 6;

  localparam logic [FRAME_BITS-1:0]    FRAME_MARK   = 5'b11111;
  localparam logic [BLOCK_ID_BITS-1:0] TAG_BLOCK_ID = 6'h3F;

  localparam int TAG_PAD_BITS = DATA_BITS - FRAME_BITS - 1 - BLOCK_ID_BITS - PERIOD_BITS;

  typedef enum logic [1:0] {
    IDLE,
    TAG,
    DATA
  } state_t;

  function automatic logic [DATA_BITS-1:0] make_tag_word(input logic [PERIOD_BITS-1:0] period);
    return {FRAME_MARK, 1'b0, TAG_BLOCK_ID, {TAG_PAD_BITS{1'b0}}, period};
  endfunction

endpackage

// File: rtl/detector_stream_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational circular priority select. Searches req starting at ptr+1 and
// wrapping around; ptr itself has the lowest priority.
//
// Ports:
//   req  in  N         request vector
//   ptr  in  IDX_BITS  index of the most recently served requester
//   any  out 1         at least one request is set
//   idx  out IDX_BITS  selected requester (0 when any is low)
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N        = 4,
  parameter int IDX_BITS = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]        req,
  input  logic [IDX_BITS-1:0] ptr,
  output logic                any,
  output logic [IDX_BITS-1:0] idx
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    any = |req;
    idx = '0;
    // Walk from the farthest distance to the nearest so the closest requester
    // after ptr is the one left in idx.
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        idx = IDX_BITS'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/detector_stream_arbiter.sv
// -----------------------------------------------------------------------------
// detector_stream_arbiter
// Round-robin merge of NBLK detector event streams into one output stream.
// A time-tag word is inserted ahead of any event whose period differs from the
// last period sent, or when a tag has been requested (reset, force_tag).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   src_valid    per-source event valid
//   src_ready    per-source one-cycle accept pulse (registered)
//   src_data     event words, source i at [i*DATA_BITS +: DATA_BITS]
//   src_period   period latched with each event, source i at [i*PERIOD_BITS +: PERIOD_BITS]
//   force_tag    pulse: precede the next forwarded event with a tag
//   out_valid / out_ready / out_data / out_is_tag   output stream
//   event_count / tag_count                         wrapping statistics
// -----------------------------------------------------------------------------
module detector_stream_arbiter #(
  parameter int NBLK        = 4,
  parameter int DATA_BITS   = detector_pkg::DATA_BITS,
  parameter int PERIOD_BITS = detector_pkg::PERIOD_BITS,
  parameter int CNT_BITS    = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NBLK-1:0]             src_valid,
  output logic [NBLK-1:0]             src_ready,
  input  logic [NBLK*DATA_BITS-1:0]   src_data,
  input  logic [NBLK*PERIOD_BITS-1:0] src_period,
  input  logic                        force_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_BITS-1:0]        out_data,
  output logic                        out_is_tag,
  output logic [CNT_BITS-1:0]         event_count,
  output logic [CNT_BITS-1:0]         tag_count
);

  import detector_pkg::*;

  localparam int IDX_BITS = (NBLK > 1) ? $clog2(NBLK) : 1;

  state_t                 state, state_next;
  logic [IDX_BITS-1:0]    ptr;
  logic [IDX_BITS-1:0]    grant;
  logic [PERIOD_BITS-1:0] grant_period;
  logic [PERIOD_BITS-1:0] last_period;
  logic                   tag_needed;

  logic                   pick_any;
  logic [IDX_BITS-1:0]    pick_idx;
  logic [PERIOD_BITS-1:0] pick_period;
  logic [IDX_BITS-1:0]    data_idx;
  logic [DATA_BITS-1:0]   data_word;
  logic                   out_ack;
  logic                   load_tag;
  logic                   load_data;

  rr_pick #(
    .N        (NBLK),
    .IDX_BITS (IDX_BITS)
  ) u_pick (
    .req (src_valid),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign pick_period = src_period[int'(pick_idx)*PERIOD_BITS +: PERIOD_BITS];
  assign data_word   = src_data[int'(data_idx)*DATA_BITS +: DATA_BITS];
  assign out_ack     = out_valid & out_ready;

  // Next state and load strobes. In TAG the event source is the one latched
  // when the tag was chosen, not whatever the picker currently sees.
  always_comb begin
    state_next = state;
    load_tag   = 1'b0;
    load_data  = 1'b0;
    data_idx   = pick_idx;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          if (tag_needed || (pick_period != last_period)) begin
            load_tag   = 1'b1;
            state_next = TAG;
          end else begin
            load_data  = 1'b1;
            state_next = DATA;
          end
        end
      end
      TAG: begin
        data_idx = grant;
        if (out_ack) begin
          load_data  = 1'b1;
          state_next = DATA;
        end
      end
      DATA: begin
        if (out_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // in the design samples pre-edge values, independent of block ordering.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: out_data is datapath but is reset anyway, so an abandoned word is
    // never visible downstream and reset values are fully defined.
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_is_tag   <= 1'b0;
      out_data     <= '0;
      src_ready    <= '0;
      event_count  <= '0;
      tag_count    <= '0;
      ptr          <= IDX_BITS'(NBLK - 1);
      grant        <= '0;
      grant_period <= '0;
      last_period  <= '0;
      tag_needed   <= 1'b1;
    end else begin
      src_ready <= load_data ? (NBLK'(1) << data_idx) : '0;

      if (load_tag) begin
        out_data     <= make_tag_word(pick_period);
        out_is_tag   <= 1'b1;
        out_valid    <= 1'b1;
        grant        <= pick_idx;
        grant_period <= pick_period;
      end

      if (load_data) begin
        out_data   <= data_word;
        out_is_tag <= 1'b0;
        out_valid  <= 1'b1;
        ptr        <= data_idx;
      end

      if (state == TAG && out_ack) begin
        last_period <= grant_period;
        tag_count   <= tag_count + 1'b1;
      end

      if (state == DATA && out_ack) begin
        out_valid   <= 1'b0;
        event_count <= event_count + 1'b1;
      end

      // force_tag has priority over a tag acknowledge in the same cycle.
      if (force_tag)                     tag_needed <= 1'b1;
      else if (state == TAG && out_ack)  tag_needed <= 1'b0;
    end
  end

endmodule
